// File: rtl/mkmif_pkg.sv
// Constants shared between the MKM interface master and the 23K640 SRAM emulator:
// SPI opcodes, status-register mode field encodings and the emulator FSM states.
package mkmif_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_WRSR  = 8'h01;

  // Sequential mode with HOLD disabled: what the master writes at init.
  localparam logic [7:0] SEQ_MODE_NO_HOLD = 8'h41;

  typedef enum logic [1:0] {
    MODE_BYTE = 2'b00,
    MODE_SEQ  = 2'b01,
    MODE_PAGE = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_RDSR,
    ST_WRSR,
    ST_IGNORE
  } state_e;

  function automatic logic mode_advances(input mode_e mode);
    return (mode == MODE_SEQ) || (mode == MODE_PAGE);
  endfunction

endpackage

// File: rtl/mkmif_sram_emu_if.sv
// SPI link between the MKM interface master and the SRAM (or its emulator).
interface mkmif_sram_emu_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_di;
  logic spi_do;

  modport master (output spi_sclk, output spi_cs_n, output spi_di, input spi_do);
  modport slave  (input spi_sclk, input spi_cs_n, input spi_di, output spi_do);
endinterface

// File: rtl/mkmif_sram_emu_mem.sv
// Byte array for the SRAM emulator: one write port, two registered read ports
// (SPI prefetch and backdoor). Read-during-write returns the old byte.
module mkmif_sram_emu_mem #(
  parameter int ADDR_BITS = 13
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [7:0]           wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [7:0]           rd_data_o,
  input  logic [ADDR_BITS-1:0] bd_addr_i,
  output logic [7:0]           bd_data_o
);

  logic [7:0] mem_q [2**ADDR_BITS];
  logic [7:0] rd_data_q;
  logic [7:0] bd_data_q;

  // NOTE: the array itself has no reset; resetting it would stop it mapping to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
      bd_data_q <= '0;
    end else begin
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
      bd_data_q <= mem_q[bd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;
  assign bd_data_o = bd_data_q;

endmodule

// File: rtl/mkmif_sram_emu.sv
// SPI-mode-0 slave emulating a 23K640 serial SRAM. SPI pins are oversampled in
// the clk domain; command decode, addressing and shifters live here.
module mkmif_sram_emu
  import mkmif_pkg::*;
#(
  parameter int ADDR_BITS = 13,
  parameter int PAGE_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mkmif_sram_emu_if.slave      spi,
  output logic [7:0]           status,
  output logic                 busy,
  output logic                 illegal_cmd,
  input  logic [ADDR_BITS-1:0] bd_addr,
  output logic [7:0]           bd_rd_data
);

  // Only the low ADDR_BITS of the 16-bit address are kept; upper bits shift out.
  localparam int SH_W = ADDR_BITS - 1;

  typedef logic [ADDR_BITS-1:0] addr_t;

  // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
  logic [2:0] sclk_sync_q, cs_sync_q;
  logic [1:0] di_sync_q;

  // NOTE: non-blocking so each stage captures the previous stage's old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      di_sync_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi.spi_sclk};
      cs_sync_q   <= {cs_sync_q[1:0], spi.spi_cs_n};
      di_sync_q   <= {di_sync_q[0], spi.spi_di};
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, di_s;
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign di_s      = di_sync_q[1];

  state_e          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [SH_W-1:0] in_shift_q, in_shift_d;
  logic [7:0]      out_shift_q, out_shift_d;
  addr_t           addr_q, addr_d;
  logic            is_read_q, is_read_d;
  logic            done_q, done_d;
  logic            load_q, load_d;
  logic [7:0]      status_q, status_d;
  logic            spi_do_q, spi_do_d;
  logic            illegal_q, illegal_d;

  logic            mem_wr_en, mem_rd_en;
  addr_t           mem_rd_addr;
  logic [7:0]      mem_rd_data;

  addr_t           in_word;
  logic [7:0]      in_byte;
  mode_e           mode;
  logic            advance;
  addr_t           addr_next;
  logic [PAGE_BITS-1:0] page_off;

  assign in_word = {in_shift_q, di_s};
  assign in_byte = in_word[7:0];
  assign mode    = mode_e'(status_q[7:6]);
  assign advance = mode_advances(mode);

  always_comb begin
    page_off  = addr_q[PAGE_BITS-1:0] + PAGE_BITS'(1);
    addr_next = addr_q;
    case (mode)
      MODE_SEQ:  addr_next = addr_q + ADDR_BITS'(1);
      MODE_PAGE: addr_next = {addr_q[ADDR_BITS-1:PAGE_BITS], page_off};
      default:   addr_next = addr_q;
    endcase
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    in_shift_d  = in_shift_q;
    out_shift_d = out_shift_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    done_d      = done_q;
    load_d      = 1'b0;
    status_d    = status_q;
    spi_do_d    = spi_do_q;
    illegal_d   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = addr_q;

    if (load_q) out_shift_d = mem_rd_data;

    if (cs_rise) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      out_shift_d = '0;
      spi_do_d    = 1'b0;
    end else if (cs_fall) begin
      state_d     = ST_CMD;
      bit_cnt_d   = '0;
      in_shift_d  = '0;
      out_shift_d = '0;
      spi_do_d    = 1'b0;
      done_d      = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (sclk_fall) begin
        spi_do_d    = out_shift_q[7];
        out_shift_d = {out_shift_q[6:0], 1'b0};
      end
      if (sclk_rise) begin
        in_shift_d = in_word[SH_W-1:0];
        bit_cnt_d  = bit_cnt_q + 4'd1;
        case (state_q)
          ST_CMD: if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            case (in_byte)
              CMD_READ:  begin state_d = ST_ADDR; is_read_d = 1'b1; end
              CMD_WRITE: begin state_d = ST_ADDR; is_read_d = 1'b0; end
              CMD_RDSR:  begin state_d = ST_RDSR; out_shift_d = status_q; end
              CMD_WRSR:  state_d = ST_WRSR;
              default:   begin state_d = ST_IGNORE; illegal_d = 1'b1; end
            endcase
          end
          ST_ADDR: if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = '0;
            addr_d    = in_word;
            done_d    = 1'b0;
            if (is_read_q) begin
              state_d     = ST_RD_DATA;
              mem_rd_en   = 1'b1;
              mem_rd_addr = in_word;
              load_d      = 1'b1;
            end else begin
              state_d = ST_WR_DATA;
            end
          end
          ST_WR_DATA: if (bit_cnt_q[2:0] == 3'd7 && !done_q) begin
            mem_wr_en = 1'b1;
            addr_d    = addr_next;
            done_d    = !advance;
          end
          // Byte/reserved modes read one byte only; the drained shifter then drives 0.
          ST_RD_DATA: if (bit_cnt_q[2:0] == 3'd7) begin
            if (advance) begin
              addr_d      = addr_next;
              mem_rd_en   = 1'b1;
              mem_rd_addr = addr_next;
              load_d      = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
          ST_WRSR: if (bit_cnt_q == 4'd7 && !done_q) begin
            status_d = in_byte;
            done_d   = 1'b1;
          end
          ST_RDSR: if (bit_cnt_q[2:0] == 3'd7) out_shift_d = status_q;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      in_shift_q  <= '0;
      out_shift_q <= '0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      done_q      <= 1'b0;
      load_q      <= 1'b0;
      status_q    <= '0;
      spi_do_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      in_shift_q  <= in_shift_d;
      out_shift_q <= out_shift_d;
      addr_q      <= addr_d;
      is_read_q   <= is_read_d;
      done_q      <= done_d;
      load_q      <= load_d;
      status_q    <= status_d;
      spi_do_q    <= spi_do_d;
      illegal_q   <= illegal_d;
    end
  end

  mkmif_sram_emu_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (mem_wr_en),
    .wr_addr_i (addr_q),
    .wr_data_i (in_byte),
    .rd_en_i   (mem_rd_en),
    .rd_addr_i (mem_rd_addr),
    .rd_data_o (mem_rd_data),
    .bd_addr_i (bd_addr),
    .bd_data_o (bd_rd_data)
  );

  assign spi.spi_do  = spi_do_q;
  assign status      = status_q;
  assign busy        = ~cs_sync_q[1];
  assign illegal_cmd = illegal_q;

endmodule

// File: tb/tb_mkmif_sram_emu.sv
// Randomized scoreboard bench for mkmif_sram_emu: a bit-level SPI master drives
// transactions while a behavioural SRAM model predicts every byte read back.
module tb_mkmif_sram_emu;
  import mkmif_pkg::*;

  localparam int AB   = 13;
  localparam int SIZE = 2**AB;
  localparam int HALF = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    status;
  logic          busy, illegal_cmd;
  logic [AB-1:0] bd_addr;
  logic [7:0]    bd_rd_data;

  mkmif_sram_emu_if spi ();

  always #5 clk = ~clk;

  mkmif_sram_emu #(.ADDR_BITS(AB), .PAGE_BITS(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi         (spi),
    .status      (status),
    .busy        (busy),
    .illegal_cmd (illegal_cmd),
    .bd_addr     (bd_addr),
    .bd_rd_data  (bd_rd_data)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: sparse byte array plus the status register
  logic [7:0] mem_m [int];
  logic [7:0] stat_m = 8'h00;

  function automatic int adv(input int a, input logic [1:0] m);
    case (m)
      2'b01:   return (a + 1) % SIZE;
      2'b10:   return (a / 32) * 32 + (a + 1) % 32;
      default: return a;
    endcase
  endfunction

  function automatic bit one_byte_mode(input logic [1:0] m);
    return (m == 2'b00) || (m == 2'b11);
  endfunction

  // Scoreboard: expected read bytes, -1 meaning "not known to the model"
  int         exp_q[$];
  bit         mon_on = 1'b0;
  int         mon_skip = 0;
  int         mon_bits = 0;
  int         mon_e;
  logic [7:0] mon_sh = '0;

  always @(posedge spi.spi_sclk or negedge spi.spi_cs_n) begin
    if (!spi.spi_sclk) begin
      mon_bits = 0;
    end else if (!spi.spi_cs_n) begin
      if (mon_on && mon_bits >= mon_skip) begin
        mon_sh = {mon_sh[6:0], spi.spi_do};
        if ((mon_bits - mon_skip) % 8 == 7) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL rx_extra: got 0x%0h, expected no byte", mon_sh);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e >= 0) check("rx_byte", {24'd0, mon_sh}, mon_e);
          end
        end
      end
      mon_bits++;
    end
  end

  int ill_cnt = 0;
  int do_hi   = 0;
  always @(negedge clk) begin
    if (illegal_cmd) ill_cnt++;
    if (spi.spi_do) do_hi++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    spi.spi_di = b;
    wait_clk(HALF);
    spi.spi_sclk = 1'b1;
    wait_clk(HALF);
    spi.spi_sclk = 1'b0;
  endtask

  logic [7:0] tx_q[$];
  logic [7:0] dq[$];

  task automatic spi_run(input int nbits);
    logic [7:0] cur;
    spi.spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      cur = tx_q[i / 8];
      spi_bit(cur[7 - (i % 8)]);
    end
    wait_clk(HALF);
    spi.spi_cs_n = 1'b1;
    spi.spi_di   = 1'b0;
    wait_clk(2 * HALF);
    tx_q.delete();
  endtask

  // WRITE of dq at addr16; part_bits>0 sends only that many bits of the last byte
  task automatic wr(input int addr16, input int part_bits);
    int a, nfull;
    bit done;
    tx_q.push_back(CMD_WRITE);
    tx_q.push_back(8'(addr16 >> 8));
    tx_q.push_back(8'(addr16));
    foreach (dq[k]) tx_q.push_back(dq[k]);
    nfull = (part_bits > 0) ? dq.size() - 1 : dq.size();
    a = addr16 % SIZE;
    done = 1'b0;
    for (int k = 0; k < nfull; k++) begin
      if (!done) begin
        mem_m[a] = dq[k];
        a = adv(a, stat_m[7:6]);
        done = one_byte_mode(stat_m[7:6]);
      end
    end
    mon_on = 1'b0;
    spi_run(24 + 8 * nfull + part_bits);
    dq.delete();
  endtask

  task automatic rd(input int addr16, input int n);
    int a;
    tx_q.push_back(CMD_READ);
    tx_q.push_back(8'(addr16 >> 8));
    tx_q.push_back(8'(addr16));
    a = addr16 % SIZE;
    for (int k = 0; k < n; k++) begin
      tx_q.push_back(8'h00);
      if (k > 0 && one_byte_mode(stat_m[7:6])) exp_q.push_back(0);
      else exp_q.push_back(mem_m.exists(a) ? int'(mem_m[a]) : -1);
      a = adv(a, stat_m[7:6]);
    end
    mon_skip = 24;
    mon_on   = 1'b1;
    spi_run(24 + 8 * n);
    mon_on   = 1'b0;
    check("rd_bytes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Trailing 0xFF byte must not overwrite the status just written
  task automatic wrsr(input logic [7:0] v);
    tx_q.push_back(CMD_WRSR);
    tx_q.push_back(v);
    tx_q.push_back(8'hFF);
    stat_m = v;
    mon_on = 1'b0;
    spi_run(24);
  endtask

  task automatic rdsr(input int n);
    tx_q.push_back(CMD_RDSR);
    for (int k = 0; k < n; k++) begin
      tx_q.push_back(8'h00);
      exp_q.push_back(int'(stat_m));
    end
    mon_skip = 8;
    mon_on   = 1'b1;
    spi_run(8 + 8 * n);
    mon_on   = 1'b0;
    check("rdsr_bytes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic bd_chk(input int a, input string name);
    bd_addr = AB'(a);
    wait_clk(2);
    check(name, bd_rd_data, mem_m[a]);
  endtask

  initial begin
    wait_clk(90000);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int ill0, op, addr, len;
    logic [7:0] d;
    logic [15:0] rd_cmd;

    spi.spi_sclk = 1'b0;
    spi.spi_cs_n = 1'b1;
    spi.spi_di   = 1'b0;
    bd_addr      = '0;
    wait_clk(3);
    check("rst_spi_do", spi.spi_do, 0);
    check("rst_status", status, 0);
    check("rst_busy", busy, 0);
    check("rst_illegal", illegal_cmd, 0);
    check("rst_bd", bd_rd_data, 0);
    reset_n = 1'b1;
    wait_clk(4);

    // Status register
    rdsr(1);
    wrsr(SEQ_MODE_NO_HOLD);
    rdsr(2);
    check("status_41", status, stat_m);

    // Sequential write/read
    dq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    wr(16'h0010, 0);
    rd(16'h0010, 4);
    bd_chk(16'h0010, "bd_0010");

    // Sequential wrap and upper-address aliasing
    dq = '{8'h11, 8'h22};
    wr(16'h1FFF, 0);
    bd_chk(16'h1FFF, "bd_1fff");
    bd_chk(16'h0000, "bd_0000");
    rd(16'hFFFF, 1);

    // Page wrap
    dq = '{8'h77};
    wr(16'h0040, 0);
    wrsr(8'h80);
    dq = '{8'hA0, 8'hA1};
    wr(16'h003F, 0);
    bd_chk(16'h003F, "bd_003f");
    bd_chk(16'h0020, "bd_0020");
    bd_chk(16'h0040, "bd_0040");

    // Byte mode and partial-byte abort
    wrsr(SEQ_MODE_NO_HOLD);
    dq = '{8'h99, 8'h5A};
    wr(16'h0101, 0);
    wrsr(8'h00);
    dq = '{8'h55, 8'h66};
    wr(16'h0100, 0);
    bd_chk(16'h0100, "bd_0100");
    bd_chk(16'h0101, "bd_0101");
    rd(16'h0100, 2);
    dq = '{8'hC3};
    wr(16'h0102, 5);
    bd_chk(16'h0102, "bd_0102_abort");

    // Illegal command
    ill0  = ill_cnt;
    do_hi = 0;
    tx_q  = '{8'hAB, 8'hFF, 8'hFF};
    spi_run(24);
    check("illegal_pulses", ill_cnt - ill0, 1);
    check("illegal_do_high", do_hi, 0);
    rdsr(1);

    // Reset in the middle of a READ of 0x0010 (0xDE), after three data bits
    wrsr(SEQ_MODE_NO_HOLD);
    rd_cmd = 16'h0010;
    spi.spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 7; i >= 0; i--) spi_bit(CMD_READ[i]);
    for (int i = 15; i >= 0; i--) spi_bit(rd_cmd[i]);
    for (int i = 0; i < 3; i++) spi_bit(1'b0);
    wait_clk(HALF);
    d = mem_m[16'h0010];
    check("mid_read_do", spi.spi_do, d[4]);
    check("mid_read_busy", busy, 1);
    reset_n = 1'b0;
    stat_m  = 8'h00;
    wait_clk(1);
    check("reset_do", spi.spi_do, 0);
    check("reset_status", status, stat_m);
    spi.spi_cs_n = 1'b1;
    wait_clk(HALF);
    reset_n = 1'b1;
    wait_clk(4);
    rdsr(1);
    rd(16'h0010, 1);

    // Randomized traffic inside a prefilled 64-byte window at 0x0300
    wrsr(SEQ_MODE_NO_HOLD);
    for (int k = 0; k < 64; k++) dq.push_back(8'($urandom));
    wr(16'h0300, 0);
    for (int it = 0; it < 24; it++) begin
      d = {2'($urandom), 5'd0, 1'($urandom)};
      wrsr(d);
      addr = int'($urandom & 32'hE000) | (16'h0300 + int'($urandom_range(0, 31)));
      len  = int'($urandom_range(1, 5));
      op   = int'($urandom_range(0, 2));
      if (op == 0) begin
        for (int k = 0; k < len; k++) dq.push_back(8'($urandom));
        wr(addr, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
      end else if (op == 1) begin
        rd(addr, len);
      end else begin
        rdsr(1);
      end
    end
    check("status_final", status, stat_m);
    for (int k = 0; k < 8; k++) bd_chk(16'h0300 + int'($urandom_range(0, 63)), "bd_random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mkmif_sram_emu.md
# mkmif_sram_emu

Synthesizable SPI slave that emulates the Microchip 23K640 serial SRAM. It is the far end of the MKM interface master's SPI link and is used in FPGA bring-up and simulation benches without the external part. It decodes READ (0x03), WRITE (0x02), RDSR (0x05) and WRSR (0x01) and implements byte, page and sequential modes. Backing storage is an on-chip byte array. All SPI inputs are oversampled in the `clk` domain.

## Interface
- `ADDR_BITS`, default 13: byte address width. The array holds 2**ADDR_BITS bytes (8 KiB = 23K640).
- `PAGE_BITS`, default 5: page size 2**PAGE_BITS bytes (32).
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `spi_sclk` in 1: SPI clock from the master. Mode 0 (CPOL=0, CPHA=0).
- `spi_cs_n` in 1: chip select, active low.
- `spi_di` in 1: serial data master→SRAM (MOSI).
- `spi_do` out 1: serial data SRAM→master (MISO). Driven 0 when not outputting.
- `status` out 8: current status register.
- `busy` out 1: high while synchronized cs_n is low.
- `illegal_cmd` out 1: one-cycle pulse when an unsupported command byte completes.
- `bd_addr` in ADDR_BITS: backdoor read address (bench/debug).
- `bd_rd_data` out 8: array byte at `bd_addr`, registered, 1-cycle latency.

## Operation
- **Synchronization:** `spi_sclk`, `spi_cs_n` and `spi_di` each pass through 2-flop synchronizers. Rise and fall of SCLK are detected from the synchronized value. `spi_di` is sampled on a detected rise. `spi_do` changes only after a detected fall, or on cs_n fall for the first read bit.
- **Bit order:** all fields are MSB first. The address is 16 bits; only the low ADDR_BITS bits are used and the upper bits are ignored.
- **FSM states:** IDLE, CMD, ADDR, RD_DATA, WR_DATA, RDSR, WRSR, IGNORE.
  - IDLE→CMD on synchronized cs_n fall.
  - CMD, after 8 bits:
    - 0x03 or 0x02 → ADDR.
    - 0x05 → RDSR. The status byte loads into the output shifter.
    - 0x01 → WRSR.
    - Any other byte → IGNORE and pulse `illegal_cmd`.
  - ADDR, after 16 bits: → RD_DATA (issue array read; byte lands in the output shifter before the next SCLK fall) or → WR_DATA.
  - WR_DATA: each complete 8th bit commits the byte to the array at the current address, then advances the address.
  - RD_DATA: each 8th bit sampled advances the address and prefetches the next byte.
  - WRSR: after 8 bits, status ← received byte. Further bits are ignored.
  - RDSR: after 8 bits the status byte repeats.
  - Synchronized cs_n rise from any state → IDLE. A partial byte is discarded (no write, no status update) and `spi_do` ← 0.
- **Address advance** uses status[7:6]:
  - 00 (byte) and 11 (reserved): no advance. After the first data byte, reads drive 0 and writes are ignored until cs_n rises.
  - 10 (page): low PAGE_BITS increment and wrap within the page; upper bits are held.
  - 01 (sequential): full address increments and wraps from 2**ADDR_BITS−1 to 0.
- **Status bits:** all 8 bits are stored as written. Bit 0 (HOLD disable) is stored only; there is no HOLD pin.
- **Array contents** are not reset.

## Timing
- **Reset values:** `spi_do`=0, `status`=0x00, `busy`=0, `illegal_cmd`=0, `bd_rd_data`=0, FSM=IDLE, shifters=0, address=0.
- Reset asserted mid-transaction returns to IDLE immediately. The array keeps committed bytes.
- **SCLK limits:** high and low phases must each be ≥4 `clk` cycles. CS_n setup before the first SCLK rise and hold after the last SCLK fall must each be ≥4 `clk` cycles. Faster SCLK is unsupported and unchecked.
- `spi_do` updates 3 `clk` cycles after the SCLK fall at the pins: 2 sync cycles plus 1 register cycle.
- An array write occurs 3 `clk` cycles after the SCLK rise carrying bit 0 of the byte.
- `illegal_cmd` asserts 3 `clk` cycles after the 8th command rise.
- **Simultaneous events:** a detected cs_n rise takes priority over a SCLK edge in the same cycle. A backdoor read and an SPI write to the same address in the same cycle return the old byte.

## Structure
- Shared package `mkmif_pkg` holds:
  - Command opcodes: READ 0x03, WRITE 0x02, RDSR 0x05, WRSR 0x01.
  - Mode encodings: BYTE 2'b00, SEQ 2'b01, PAGE 2'b10.
  - The SEQ_MODE_NO_HOLD constant 0x41.
  - These constants are shared with the master core.
- Sub-module `mkmif_sram_emu_mem`: single-clock byte array with one write port and two registered read ports (SPI prefetch, backdoor). It maps to block RAM.
- The FSM, synchronizers and shifters live in the top.

## Test plan
- **WRSR/RDSR:** after reset, RDSR returns 0x00. WRSR 0x41 then RDSR returns 0x41, and `status`=0x41.
- **Sequential write/read:** in mode 0x41, WRITE @0x0010 bytes DE AD BE EF, cs up. READ @0x0010 for 4 bytes returns DEADBEEF; the backdoor shows 0xDE at 0x0010.
- **Sequential wrap:** write 0x11, 0x22 starting @0x1FFF. `bd_rd_data` shows 0x1FFF=0x11 and 0x0000=0x22. Address 0xFFFF aliases to 0x1FFF.
- **Page wrap:** status 0x80, write 0xA0, 0xA1 @0x003F. Result: 0x003F=0xA0, 0x0020=0xA1, 0x0040 unchanged.
- **Byte mode and partial abort:** status 0x00, write 0x55, 0x66 @0x0100. 0x0101 is unchanged and a read of 2 bytes returns 0x55, 0x00. Then a WRITE that raises cs_n after 5 data bits leaves the target byte unchanged.
- **Illegal command and reset:** command 0xAB gives one `illegal_cmd` pulse and `spi_do` stays 0 for 16 clocks. Asserting reset_n mid-READ gives `spi_do`=0 and `status`=0x00, and the next command decodes correctly.
